bconv3x3_stream_engine: RTL and testbench

//  Parametrised binary 3x3 convolution engine (XNOR-popcount-threshold) for the BNN accelerator.

---
 rtl/bconv3x3_stream_engine_if.sv | 43 ++++
 rtl/bconv3x3_stream_engine.sv | 197 +++++++++++++++++++
 tb/tb_bconv3x3_stream_engine.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bconv3x3_stream_engine_if.sv
// Handshake and SRAM bus bundle for the binary 3x3 convolution engine.
// The engine connects through the master modport; the host/memory side uses slave.
interface bconv3x3_stream_engine_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);
    logic              dut_run;
    logic              dut_busy;
    logic              dut_error;
    logic [ADDR_W-1:0] dut_sram_read_address;
    logic [DATA_W-1:0] sram_dut_read_data;
    logic [ADDR_W-1:0] dut_sram_write_address;
    logic [DATA_W-1:0] dut_sram_write_data;
    logic              dut_sram_write_enable;
    logic [ADDR_W-1:0] dut_wmem_read_address;
    logic [DATA_W-1:0] wmem_dut_read_data;

    modport master (
        input  dut_run,
        output dut_busy,
        output dut_error,
        output dut_sram_read_address,
        input  sram_dut_read_data,
        output dut_sram_write_address,
        output dut_sram_write_data,
        output dut_sram_write_enable,
        output dut_wmem_read_address,
        input  wmem_dut_read_data
    );

    modport slave (
        output dut_run,
        input  dut_busy,
        input  dut_error,
        input  dut_sram_read_address,
        output sram_dut_read_data,
        input  dut_sram_write_address,
        input  dut_sram_write_data,
        input  dut_sram_write_enable,
        input  dut_wmem_read_address,
        output wmem_dut_read_data
    );
endinterface

// File: rtl/bconv3x3_stream_engine.sv
// Streaming binary 3x3 convolution (XNOR-popcount-threshold) over a list of square images.
// Optional BCONV_IMG_COUNT_EN adds an img_count output (images completed this run, saturating).
module bconv3x3_stream_engine #(
    parameter int MAX_DIM    = 16,
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 12,
    parameter int WMEM_KADDR = 1
) (
    input  logic clk,
    input  logic reset_b,
    bconv3x3_stream_engine_if.master bus
`ifdef BCONV_IMG_COUNT_EN
    ,
    output logic [7:0] img_count
`endif
);
    localparam int CNT_W = $clog2(MAX_DIM + 1);

    typedef enum logic [2:0] {IDLE, WLOAD, HDR, FILL, RUN} state_t;

    state_t            state;
    logic              wl_phase;
    logic [CNT_W-1:0]  n_q;
    logic [CNT_W-1:0]  iss;
    logic [CNT_W-1:0]  rcv;
    logic [ADDR_W-1:0] wr_ptr;
    logic              vld_p0;
    logic [8:0]        kernel;
    logic [3:0]        thresh;
    logic [DATA_W-1:0] win_top_p0;
    logic [DATA_W-1:0] win_mid_p0;
    logic [DATA_W-1:0] row_out;
    logic [4:0]        hdr_n;
    logic              hdr_term;
    logic              hdr_bad;
    logic              row_last;
    logic              wr_go;
    logic              unused_bits;
`ifdef BCONV_IMG_COUNT_EN
    logic [7:0]        img_cnt;
`endif

    function automatic logic [3:0] popcount9(input logic [8:0] v);
        logic [3:0] c;
        c = '0;
        for (int b = 0; b < 9; b++) begin
            c = c + {3'b000, v[b]};
        end
        return c;
    endfunction

    // Window bit order: [2:0] oldest row, [8:6] newest row, column i at the LSB of each triple.
    function automatic logic [DATA_W-1:0] conv_row(
        input logic [DATA_W-1:0] t,
        input logic [DATA_W-1:0] m,
        input logic [DATA_W-1:0] b,
        input logic [8:0]        k,
        input logic [3:0]        th,
        input logic [CNT_W-1:0]  n
    );
        logic [DATA_W-1:0] r;
        logic [8:0]        w;
        r = '0;
        for (int i = 0; i < MAX_DIM - 2; i++) begin
            if (i < int'(n) - 2) begin
                w    = {b[i +: 3], m[i +: 3], t[i +: 3]};
                r[i] = (popcount9(~(k ^ w)) >= th);
            end
        end
        return r;
    endfunction

    assign hdr_n       = bus.sram_dut_read_data[4:0];
    assign hdr_term    = (bus.sram_dut_read_data[7:0] == 8'hFF);
    assign hdr_bad     = (hdr_n < 5'd3) || (int'(hdr_n) > MAX_DIM);
    assign row_last    = vld_p0 && (rcv == n_q - CNT_W'(1));
    assign wr_go       = vld_p0 && (rcv >= CNT_W'(2));
    assign unused_bits = ^{bus.sram_dut_read_data[DATA_W-1:8], bus.wmem_dut_read_data[DATA_W-1:13]};

    // Stage p0: incoming row plus the two previous rows form the 3x3 window.
    assign row_out = conv_row(win_top_p0, win_mid_p0, bus.sram_dut_read_data, kernel, thresh, n_q);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state                      <= IDLE;
            wl_phase                   <= 1'b0;
            n_q                        <= '0;
            iss                        <= '0;
            rcv                        <= '0;
            wr_ptr                     <= '0;
            vld_p0                     <= 1'b0;
            bus.dut_busy               <= 1'b0;
            bus.dut_error              <= 1'b0;
            bus.dut_sram_read_address  <= '0;
            bus.dut_sram_write_address <= '0;
            bus.dut_sram_write_data    <= '0;
            bus.dut_sram_write_enable  <= 1'b0;
            bus.dut_wmem_read_address  <= '0;
`ifdef BCONV_IMG_COUNT_EN
            img_cnt                    <= '0;
`endif
        end else begin
            bus.dut_sram_write_enable <= 1'b0;
            vld_p0                    <= 1'b0;

            // Stage p1: registered write port, one cycle after the row that completes a window.
            if (wr_go) begin
                bus.dut_sram_write_enable  <= 1'b1;
                bus.dut_sram_write_address <= wr_ptr;
                bus.dut_sram_write_data    <= row_out;
                wr_ptr                     <= wr_ptr + ADDR_W'(1);
            end
            if (vld_p0) begin
                rcv <= row_last ? '0 : rcv + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (bus.dut_run) begin
                        state                     <= WLOAD;
                        wl_phase                  <= 1'b0;
                        bus.dut_busy              <= 1'b1;
                        bus.dut_error             <= 1'b0;
                        bus.dut_wmem_read_address <= ADDR_W'(WMEM_KADDR);
                        bus.dut_sram_read_address <= '0;
                        wr_ptr                    <= '0;
                        iss                       <= '0;
                        rcv                       <= '0;
`ifdef BCONV_IMG_COUNT_EN
                        img_cnt                   <= '0;
`endif
                    end
                end
                WLOAD: begin
                    // Header address 0 is already presented, so its data lands in HDR.
                    if (!wl_phase) begin
                        wl_phase <= 1'b1;
                    end else begin
                        state                     <= HDR;
                        bus.dut_wmem_read_address <= '0;
                    end
                end
                HDR: begin
                    iss <= '0;
                    if (hdr_term) begin
                        state        <= IDLE;
                        bus.dut_busy <= 1'b0;
                    end else if (hdr_bad) begin
                        state         <= IDLE;
                        bus.dut_busy  <= 1'b0;
                        bus.dut_error <= 1'b1;
                    end else begin
                        state                     <= FILL;
                        n_q                       <= CNT_W'(hdr_n);
                        bus.dut_sram_read_address <= bus.dut_sram_read_address + ADDR_W'(1);
                    end
                end
                FILL, RUN: begin
                    // After the last row is issued the address rests on the next header.
                    if (iss != n_q) begin
                        bus.dut_sram_read_address <= bus.dut_sram_read_address + ADDR_W'(1);
                        iss                       <= iss + CNT_W'(1);
                        vld_p0                    <= 1'b1;
                    end
                    if (vld_p0 && (rcv == CNT_W'(1))) begin
                        state <= RUN;
                    end
                    if (row_last) begin
                        state <= HDR;
`ifdef BCONV_IMG_COUNT_EN
                        if (img_cnt != 8'hFF) begin
                            img_cnt <= img_cnt + 8'd1;
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((state == WLOAD) && wl_phase) begin
            kernel <= bus.wmem_dut_read_data[8:0];
            thresh <= bus.wmem_dut_read_data[12:9];
        end
        if (vld_p0) begin
            win_top_p0 <= win_mid_p0;
            win_mid_p0 <= bus.sram_dut_read_data;
        end
    end

`ifdef BCONV_IMG_COUNT_EN
    assign img_count = img_cnt;
`endif

endmodule

// File: tb/tb_bconv3x3_stream_engine.sv
// Scoreboard bench for bconv3x3_stream_engine: images are written into a modelled input SRAM,
// expected output rows are queued as each image is built and popped on every DUT write.
module tb_bconv3x3_stream_engine;
    logic clk = 1'b0;
    logic reset_b = 1'b0;
    always #5 clk = ~clk;

    bconv3x3_stream_engine_if #(.DATA_W(16), .ADDR_W(12)) bus ();
`ifdef BCONV_IMG_COUNT_EN
    logic [7:0] img_count;
`endif

    bconv3x3_stream_engine #(
        .MAX_DIM(16), .DATA_W(16), .ADDR_W(12), .WMEM_KADDR(1)
    ) dut (
        .clk(clk),
        .reset_b(reset_b),
        .bus(bus)
`ifdef BCONV_IMG_COUNT_EN
        ,
        .img_count(img_count)
`endif
    );

    logic [15:0] imem [4096];
    logic [15:0] wmem [4096];

    always @(posedge clk) begin
        bus.sram_dut_read_data <= imem[bus.dut_sram_read_address];
        bus.wmem_dut_read_data <= wmem[bus.dut_wmem_read_address];
    end

    typedef struct {
        logic [11:0] a;
        logic [15:0] d;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          nwr = 0;
    int          cyc = 0;
    int          last_wr_cyc = 0;
    logic [15:0] last_wr_data = '0;
    int          ptr = 0;
    int          exp_wr = 0;
    int          nexp = 0;
    logic [8:0]  kern = '0;
    int          thr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output SRAM side: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_b && bus.dut_sram_write_enable) begin
            exp_t e;
            nwr++;
            last_wr_cyc  = cyc;
            last_wr_data = bus.dut_sram_write_data;
            if (sb.size() == 0) begin
                check("unexpected_write", 32'(bus.dut_sram_write_address), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(bus.dut_sram_write_address), 32'(e.a));
                check("wr_data", 32'(bus.dut_sram_write_data), 32'(e.d));
            end
        end
    end

    task automatic start_list(input logic [8:0] k, input int t);
        kern   = k;
        thr    = t;
        ptr    = 0;
        exp_wr = 0;
        nexp   = 0;
        wmem[1] = {3'b000, 4'(t), k};
    endtask

    // mode 0: all ones, 1: checkerboard starting with 5555, 2: random
    task automatic add_img(input int n, input int mode);
        logic [15:0] rows [16];
        logic [15:0] mask;
        logic [15:0] o;
        int          cnt;
        exp_t        e;
        mask = (n == 16) ? 16'hFFFF : 16'((32'd1 << n) - 32'd1);
        imem[ptr] = 16'(n);
        ptr++;
        for (int r = 0; r < n; r++) begin
            case (mode)
                0:       rows[r] = 16'hFFFF & mask;
                1:       rows[r] = ((r % 2) == 0 ? 16'h5555 : 16'hAAAA) & mask;
                default: rows[r] = 16'($urandom) & mask;
            endcase
            imem[ptr] = rows[r];
            ptr++;
        end
        for (int r = 0; r + 2 < n; r++) begin
            o = '0;
            for (int i = 0; i < n - 2; i++) begin
                cnt = 0;
                for (int dr = 0; dr < 3; dr++) begin
                    for (int dc = 0; dc < 3; dc++) begin
                        if (rows[r + dr][i + dc] == kern[dr * 3 + dc]) cnt++;
                    end
                end
                o[i] = (cnt >= thr);
            end
            e.a = 12'(exp_wr);
            e.d = o;
            sb.push_back(e);
            exp_wr++;
            nexp++;
        end
    endtask

    task automatic end_list();
        imem[ptr] = 16'h00FF;
    endtask

    task automatic run_list(input bit exp_err);
        int w0;
        bit done;
        w0 = nwr;
        @(negedge clk);
        bus.dut_run = 1'b1;
        @(negedge clk);
        bus.dut_run = 1'b0;
        check("busy_rise", 32'(bus.dut_busy), 32'd1);
        check("error_cleared", 32'(bus.dut_error), 32'd0);
        done = 1'b0;
        for (int k = 0; k < 4000 && !done; k++) begin
            @(negedge clk);
            if (!bus.dut_busy) done = 1'b1;
        end
        check("busy_fall_seen", 32'(done), 32'd1);
        if (nexp > 0) check("busy_fall_lag", 32'(cyc - last_wr_cyc), 32'd1);
        check("write_count", 32'(nwr - w0), 32'(nexp));
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("error_flag", 32'(bus.dut_error), 32'(exp_err));
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_busy"}, 32'(bus.dut_busy), 32'd0);
        check({pfx, "_error"}, 32'(bus.dut_error), 32'd0);
        check({pfx, "_we"}, 32'(bus.dut_sram_write_enable), 32'd0);
        check({pfx, "_raddr"}, 32'(bus.dut_sram_read_address), 32'd0);
        check({pfx, "_waddr"}, 32'(bus.dut_sram_write_address), 32'd0);
        check({pfx, "_wdata"}, 32'(bus.dut_sram_write_data), 32'd0);
        check({pfx, "_wmaddr"}, 32'(bus.dut_wmem_read_address), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int wsnap;
        bit reached;
        bus.dut_run = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            imem[i] = '0;
            wmem[i] = '0;
        end
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset_b = 1'b1;

        // Single N=3 all-ones image, full-match kernel
        start_list(9'h1FF, 5);
        add_img(3, 0);
        end_list();
        run_list(1'b0);
        check("n3_data", 32'(last_wr_data), 32'h0001);

        // N=16 checkerboard against a checkerboard kernel
        start_list(9'h155, 9);
        add_img(16, 1);
        end_list();
        run_list(1'b0);

        // Back-to-back images of different sizes, contiguous output addresses
        start_list(9'($urandom), int'($urandom_range(3, 7)));
        add_img(5, 2);
        add_img(7, 2);
        add_img(16, 2);
        end_list();
        run_list(1'b0);
`ifdef BCONV_IMG_COUNT_EN
        check("img_count", 32'(img_count), 32'd3);
`endif

        // Threshold extremes
        start_list(9'($urandom), 0);
        add_img(8, 2);
        end_list();
        run_list(1'b0);
        check("t0_data", 32'(last_wr_data), 32'h003F);
        start_list(9'($urandom), 10);
        add_img(8, 2);
        end_list();
        run_list(1'b0);
        check("t10_data", 32'(last_wr_data), 32'h0000);

        // Illegal header, then a good run that must clear the error
        start_list(9'h0AA, 4);
        imem[0] = 16'h0002;
        imem[1] = 16'h00FF;
        run_list(1'b1);
        start_list(9'h0AA, 4);
        add_img(4, 2);
        end_list();
        run_list(1'b0);

        // Reset in the middle of a run, then restart from address 0
        start_list(9'h13C, 5);
        add_img(16, 2);
        end_list();
        @(negedge clk);
        bus.dut_run = 1'b1;
        @(negedge clk);
        bus.dut_run = 1'b0;
        wsnap = nwr;
        reached = 1'b0;
        for (int k = 0; k < 200 && !reached; k++) begin
            @(negedge clk);
            if (nwr >= wsnap + 5) reached = 1'b1;
        end
        check("midrun_writes_seen", 32'(reached), 32'd1);
        #2 reset_b = 1'b0;
        #1 check_outputs_zero("abort");
        sb.delete();
        wsnap = nwr;
        @(negedge clk);
        @(negedge clk);
        reset_b = 1'b1;
        repeat (6) @(negedge clk);
        check("no_write_after_abort", 32'(nwr - wsnap), 32'd0);
        start_list(9'h13C, 5);
        add_img(16, 2);
        end_list();
        run_list(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
